// File: rtl/board_state_engine.sv
// Two-side board state engine: validates and commits moves, detects captures,
// and keeps a single-level undo history behind a valid/ready move handshake.
module board_state_engine #(
  parameter int NUM_PIECES = 16,
  parameter int PIDX_W = 4,
  parameter int SQ_W = 6,
  parameter int CNT_W = 10,
  parameter logic [NUM_PIECES*SQ_W-1:0] INIT_LOC_W = 96'h20928B30D38F0070460850C4,
  parameter logic [NUM_PIECES*SQ_W-1:0] INIT_LOC_B = 96'hC31CB3D35DB7E3FE7EEBDEFC,
  parameter logic FIRST_SIDE = 1'b1
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       mv_valid,
  output logic                       mv_ready,
  input  logic                       mv_side,
  input  logic [PIDX_W-1:0]          mv_piece,
  input  logic [SQ_W-1:0]            mv_dest,
  input  logic                       undo,
  output logic [NUM_PIECES*SQ_W-1:0] loc_w,
  output logic [NUM_PIECES*SQ_W-1:0] loc_b,
  output logic [NUM_PIECES-1:0]      alive_w,
  output logic [NUM_PIECES-1:0]      alive_b,
  output logic                       turn,
  output logic                       done,
  output logic [2:0]                 status,
  output logic                       captured,
  output logic [PIDX_W-1:0]          captured_idx,
  output logic [CNT_W-1:0]           move_count
);
  // state | meaning
  // IDLE  | waiting for a move or undo request
  // EVAL  | legality checks and capture search registered
  // APPLY | commit (or drop) the move, raise done next cycle
  // UNDO  | revert the last committed move if history is valid

  localparam int TW = NUM_PIECES * SQ_W;
  localparam logic [2:0] ST_OK          = 3'd0;
  localparam logic [2:0] ST_WRONG_TURN  = 3'd1;
  localparam logic [2:0] ST_DEAD_PIECE  = 3'd2;
  localparam logic [2:0] ST_SELF_BLOCK  = 3'd3;
  localparam logic [2:0] ST_UNDO_EMPTY  = 3'd4;

  typedef enum logic [1:0] {IDLE, EVAL, APPLY, UNDO} state_t;
  state_t state_q, state_nx;

  logic [TW-1:0]         loc_w_q, loc_b_q;
  logic [NUM_PIECES-1:0] alive_w_q, alive_b_q;
  logic                  turn_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  done_q, captured_q;
  logic [2:0]            status_q;
  logic [PIDX_W-1:0]     cidx_q;

  logic                  side_q;
  logic [PIDX_W-1:0]     piece_q;
  logic [SQ_W-1:0]       dest_q;

  logic [2:0]            ev_status_q;
  logic                  ev_cap_q;
  logic [PIDX_W-1:0]     ev_cidx_q;

  logic                  hist_v_q, hist_side_q, hist_cap_q;
  logic [PIDX_W-1:0]     hist_piece_q, hist_cidx_q;
  logic [SQ_W-1:0]       hist_old_q;

  logic [TW-1:0]         own_loc, opp_loc;
  logic [NUM_PIECES-1:0] own_alive, opp_alive;
  logic                  mover_alive, self_hit, cap_hit;
  logic [SQ_W-1:0]       mover_old;
  logic [PIDX_W-1:0]     cap_idx;
  logic [2:0]            eval_status;

  assign mv_ready     = (state_q == IDLE) && !undo;
  assign loc_w        = loc_w_q;
  assign loc_b        = loc_b_q;
  assign alive_w      = alive_w_q;
  assign alive_b      = alive_b_q;
  assign turn         = turn_q;
  assign done         = done_q;
  assign status       = status_q;
  assign captured     = captured_q;
  assign captured_idx = cidx_q;
  assign move_count   = cnt_q;

  always_ff @(posedge clk) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE: begin
        if (undo)          state_nx = UNDO;
        else if (mv_valid) state_nx = EVAL;
      end
      EVAL:    state_nx = APPLY;
      APPLY:   state_nx = IDLE;
      UNDO:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Checks run on the latched request against the current tables.
  always_comb begin
    own_loc     = side_q ? loc_w_q : loc_b_q;
    opp_loc     = side_q ? loc_b_q : loc_w_q;
    own_alive   = side_q ? alive_w_q : alive_b_q;
    opp_alive   = side_q ? alive_b_q : alive_w_q;
    mover_alive = 1'b0;
    mover_old   = '0;
    self_hit    = 1'b0;
    cap_hit     = 1'b0;
    cap_idx     = '0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      if (PIDX_W'(i) == piece_q) begin
        mover_alive = own_alive[i];
        mover_old   = own_loc[i*SQ_W +: SQ_W];
      end
      if (own_alive[i] && (own_loc[i*SQ_W +: SQ_W] == dest_q)) self_hit = 1'b1;
    end
    // Descending scan so the lowest matching index is the one that sticks.
    for (int i = NUM_PIECES - 1; i >= 0; i--) begin
      if (opp_alive[i] && (opp_loc[i*SQ_W +: SQ_W] == dest_q)) begin
        cap_hit = 1'b1;
        cap_idx = PIDX_W'(i);
      end
    end
    if (side_q != turn_q)  eval_status = ST_WRONG_TURN;
    else if (!mover_alive) eval_status = ST_DEAD_PIECE;
    else if (self_hit)     eval_status = ST_SELF_BLOCK;
    else                   eval_status = ST_OK;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      loc_w_q      <= INIT_LOC_W;
      loc_b_q      <= INIT_LOC_B;
      alive_w_q    <= '1;
      alive_b_q    <= '1;
      turn_q       <= FIRST_SIDE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      status_q     <= ST_OK;
      captured_q   <= 1'b0;
      cidx_q       <= '0;
      side_q       <= 1'b0;
      piece_q      <= '0;
      dest_q       <= '0;
      ev_status_q  <= ST_OK;
      ev_cap_q     <= 1'b0;
      ev_cidx_q    <= '0;
      hist_v_q     <= 1'b0;
      hist_side_q  <= 1'b0;
      hist_cap_q   <= 1'b0;
      hist_piece_q <= '0;
      hist_cidx_q  <= '0;
      hist_old_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mv_valid && mv_ready) begin
            side_q  <= mv_side;
            piece_q <= mv_piece;
            dest_q  <= mv_dest;
          end
        end
        EVAL: begin
          ev_status_q <= eval_status;
          ev_cap_q    <= cap_hit;
          ev_cidx_q   <= cap_idx;
        end
        APPLY: begin
          done_q     <= 1'b1;
          status_q   <= ev_status_q;
          captured_q <= 1'b0;
          cidx_q     <= '0;
          if (ev_status_q == ST_OK) begin
            captured_q <= ev_cap_q;
            cidx_q     <= ev_cap_q ? ev_cidx_q : '0;
            for (int i = 0; i < NUM_PIECES; i++) begin
              if (PIDX_W'(i) == piece_q) begin
                if (side_q) loc_w_q[i*SQ_W +: SQ_W] <= dest_q;
                else        loc_b_q[i*SQ_W +: SQ_W] <= dest_q;
              end
              if (ev_cap_q && (PIDX_W'(i) == ev_cidx_q)) begin
                if (side_q) alive_b_q[i] <= 1'b0;
                else        alive_w_q[i] <= 1'b0;
              end
            end
            turn_q <= ~turn_q;
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            hist_v_q     <= 1'b1;
            hist_side_q  <= side_q;
            hist_piece_q <= piece_q;
            hist_old_q   <= mover_old;
            hist_cap_q   <= ev_cap_q;
            hist_cidx_q  <= ev_cidx_q;
          end
        end
        UNDO: begin
          done_q     <= 1'b1;
          captured_q <= 1'b0;
          cidx_q     <= '0;
          if (hist_v_q) begin
            status_q <= ST_OK;
            for (int i = 0; i < NUM_PIECES; i++) begin
              if (PIDX_W'(i) == hist_piece_q) begin
                if (hist_side_q) loc_w_q[i*SQ_W +: SQ_W] <= hist_old_q;
                else             loc_b_q[i*SQ_W +: SQ_W] <= hist_old_q;
              end
              if (hist_cap_q && (PIDX_W'(i) == hist_cidx_q)) begin
                if (hist_side_q) alive_b_q[i] <= 1'b1;
                else             alive_w_q[i] <= 1'b1;
              end
            end
            turn_q   <= ~turn_q;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            hist_v_q <= 1'b0;
          end else begin
            status_q <= ST_UNDO_EMPTY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state_engine.sv
// Self-checking bench for board_state_engine: table of moves/undos with a
// scoreboard of expected done results and a shadow board model.
module tb_board_state_engine;
  localparam logic [95:0] INIT_W = 96'h20928B30D38F0070460850C4;
  localparam logic [95:0] INIT_B = 96'hC31CB3D35DB7E3FE7EEBDEFC;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        mv_valid = 1'b0;
  logic        mv_ready;
  logic        mv_side = 1'b0;
  logic [3:0]  mv_piece = '0;
  logic [5:0]  mv_dest = '0;
  logic        undo = 1'b0;
  logic [95:0] loc_w, loc_b;
  logic [15:0] alive_w, alive_b;
  logic        turn, done, captured;
  logic [2:0]  status;
  logic [3:0]  captured_idx;
  logic [9:0]  move_count;

  board_state_engine dut (
    .clk(clk), .RST(RST), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_side(mv_side), .mv_piece(mv_piece), .mv_dest(mv_dest), .undo(undo),
    .loc_w(loc_w), .loc_b(loc_b), .alive_w(alive_w), .alive_b(alive_b),
    .turn(turn), .done(done), .status(status), .captured(captured),
    .captured_idx(captured_idx), .move_count(move_count)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {OP_MOVE, OP_UNDO, OP_RST} op_t;
  typedef struct {
    op_t        op;
    logic       side;
    logic [3:0] piece;
    logic [5:0] dest;
    logic [2:0] st;
    logic       cap;
    logic [3:0] cidx;
  } vec_t;
  typedef struct {
    logic [2:0] st;
    logic       cap;
    logic [3:0] cidx;
    int         lat;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  int n_pass = 0;
  int n_total = 0;

  logic [5:0]  m_loc_w[16];
  logic [5:0]  m_loc_b[16];
  logic [15:0] m_alive_w, m_alive_b;
  logic        m_turn;
  int          m_cnt;
  logic        h_valid, h_side, h_cap;
  logic [3:0]  h_piece, h_cidx;
  logic [5:0]  h_old;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input op_t op, input logic side, input int piece, input int dest,
                     input int st, input logic cap, input int cidx);
    vec_t v;
    v.op = op; v.side = side; v.piece = 4'(piece); v.dest = 6'(dest);
    v.st = 3'(st); v.cap = cap; v.cidx = 4'(cidx);
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    logic [95:0] iw, ib;
    iw = INIT_W;
    ib = INIT_B;
    for (int i = 0; i < 16; i++) begin
      m_loc_w[i] = iw[i*6 +: 6];
      m_loc_b[i] = ib[i*6 +: 6];
    end
    m_alive_w = '1; m_alive_b = '1; m_turn = 1'b1; m_cnt = 0;
    h_valid = 1'b0; h_side = 1'b0; h_cap = 1'b0; h_piece = '0; h_cidx = '0; h_old = '0;
  endtask

  function automatic logic [95:0] pack_loc(input bit white);
    logic [95:0] p;
    for (int i = 0; i < 16; i++) p[i*6 +: 6] = white ? m_loc_w[i] : m_loc_b[i];
    return p;
  endfunction

  // Shadow-board update driven by the hand-derived expected status of each vector.
  task automatic model_apply(input vec_t v);
    if (v.op == OP_MOVE && v.st == 3'd0) begin
      h_valid = 1'b1; h_side = v.side; h_piece = v.piece; h_cap = v.cap; h_cidx = v.cidx;
      h_old = v.side ? m_loc_w[v.piece] : m_loc_b[v.piece];
      if (v.side) m_loc_w[v.piece] = v.dest; else m_loc_b[v.piece] = v.dest;
      if (v.cap) begin
        if (v.side) m_alive_b[v.cidx] = 1'b0; else m_alive_w[v.cidx] = 1'b0;
      end
      m_turn = ~m_turn;
      if (m_cnt < 1023) m_cnt++;
    end else if (v.op == OP_UNDO && v.st == 3'd0 && h_valid) begin
      if (h_side) m_loc_w[h_piece] = h_old; else m_loc_b[h_piece] = h_old;
      if (h_cap) begin
        if (h_side) m_alive_b[h_cidx] = 1'b1; else m_alive_w[h_cidx] = 1'b1;
      end
      m_turn = ~m_turn;
      if (m_cnt > 0) m_cnt--;
      h_valid = 1'b0;
    end
  endtask

  task automatic check_board(input string tag);
    chk($sformatf("loc_w@%s", tag), 128'(loc_w), 128'(pack_loc(1'b1)));
    chk($sformatf("loc_b@%s", tag), 128'(loc_b), 128'(pack_loc(1'b0)));
    chk($sformatf("alive_w@%s", tag), 128'(alive_w), 128'(m_alive_w));
    chk($sformatf("alive_b@%s", tag), 128'(alive_b), 128'(m_alive_b));
    chk($sformatf("turn@%s", tag), 128'(turn), 128'(m_turn));
    chk($sformatf("move_count@%s", tag), 128'(move_count), 128'(m_cnt));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    RST = 1'b1; mv_valid = 1'b0; undo = 1'b0;
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    model_reset();
    #1;
    chk($sformatf("rst_done@%s", tag), 128'(done), 128'(1'b0));
    chk($sformatf("rst_status@%s", tag), 128'(status), 128'(3'd0));
    chk($sformatf("rst_captured@%s", tag), 128'({captured, captured_idx}), 128'(5'd0));
    chk($sformatf("rst_ready@%s", tag), 128'(mv_ready), 128'(1'b1));
    check_board(tag);
  endtask

  task automatic run_vec(input vec_t v, input bit with_mv, input string tag);
    exp_t e;
    int   edges;
    if (v.op == OP_RST) begin
      do_reset(tag);
      return;
    end
    @(negedge clk);
    if (v.op == OP_MOVE) begin
      mv_valid = 1'b1; mv_side = v.side; mv_piece = v.piece; mv_dest = v.dest;
    end else begin
      undo = 1'b1;
      if (with_mv) begin
        mv_valid = 1'b1; mv_side = ~m_turn; mv_piece = 4'd0; mv_dest = 6'd40;
      end
    end
    #1;
    chk($sformatf("mv_ready@%s", tag), 128'(mv_ready), 128'(v.op == OP_MOVE));
    e.st = v.st;
    e.cap = (v.op == OP_MOVE) ? v.cap : 1'b0;
    e.cidx = (v.op == OP_MOVE && v.cap) ? v.cidx : 4'd0;
    e.lat = (v.op == OP_MOVE) ? 3 : 2;
    exp_q.push_back(e);
    model_apply(v);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    mv_valid = 1'b0; undo = 1'b0;
    while (!done && edges < 10) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk($sformatf("done_seen@%s", tag), 128'(done), 128'(1'b1));
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk($sformatf("latency@%s", tag), 128'(edges), 128'(e.lat));
    chk($sformatf("status@%s", tag), 128'(status), 128'(e.st));
    chk($sformatf("captured@%s", tag), 128'(captured), 128'(e.cap));
    chk($sformatf("captured_idx@%s", tag), 128'(captured_idx), 128'(e.cidx));
    check_board(tag);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("done_pulse@%s", tag), 128'(done), 128'(1'b0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   seen;
    model_reset();
    // op, side, piece, dest, status, cap, cidx
    add(OP_RST,  1'b0,  0,  0, 0, 1'b0,  0);
    add(OP_MOVE, 1'b1, 15, 16, 0, 1'b0,  0);
    add(OP_MOVE, 1'b0, 15, 16, 0, 1'b1, 15);
    add(OP_UNDO, 1'b0,  0,  0, 0, 1'b0,  0);
    add(OP_UNDO, 1'b0,  0,  0, 4, 1'b0,  0);
    add(OP_MOVE, 1'b1, 14, 20, 1, 1'b0,  0);
    add(OP_MOVE, 1'b0, 15, 16, 0, 1'b1, 15);
    add(OP_MOVE, 1'b1, 15, 17, 2, 1'b0,  0);
    add(OP_MOVE, 1'b1, 14,  9, 3, 1'b0,  0);
    add(OP_MOVE, 1'b1, 14, 20, 0, 1'b0,  0);
    add(OP_MOVE, 1'b0, 15, 30, 0, 1'b0,  0);
    add(OP_MOVE, 1'b1, 13, 21, 0, 1'b0,  0);
    add(OP_MOVE, 1'b0, 14, 16, 0, 1'b0,  0);
    add(OP_MOVE, 1'b1, 12, 30, 0, 1'b1, 15);
    add(OP_UNDO, 1'b0,  0,  0, 0, 1'b0,  0);
    add(OP_UNDO, 1'b0,  0,  0, 4, 1'b0,  0);
    add(OP_RST,  1'b0,  0,  0, 0, 1'b0,  0);
    add(OP_MOVE, 1'b0,  0, 40, 1, 1'b0,  0);
    add(OP_MOVE, 1'b1, 15,  9, 3, 1'b0,  0);
    add(OP_UNDO, 1'b0,  0,  0, 4, 1'b0,  0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 1'b0, $sformatf("v%0d", i));

    // Undo and a legal move in the same IDLE cycle: only the undo runs.
    v = '{op: OP_MOVE, side: 1'b1, piece: 4'd15, dest: 6'd16, st: 3'd0, cap: 1'b0, cidx: 4'd0};
    run_vec(v, 1'b0, "pre_simul");
    v = '{op: OP_UNDO, side: 1'b0, piece: 4'd0, dest: 6'd0, st: 3'd0, cap: 1'b0, cidx: 4'd0};
    run_vec(v, 1'b1, "simul_undo");
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen++;
    end
    chk("simul_no_extra_done", 128'(seen), 128'(0));
    check_board("simul_after");

    // Reset while a move is in EVAL: no done, everything back to reset values.
    v = '{op: OP_MOVE, side: 1'b1, piece: 4'd15, dest: 6'd16, st: 3'd0, cap: 1'b0, cidx: 4'd0};
    run_vec(v, 1'b0, "pre_rst_eval");
    @(negedge clk);
    mv_valid = 1'b1; mv_side = 1'b0; mv_piece = 4'd15; mv_dest = 6'd40;
    @(posedge clk);
    @(negedge clk);
    mv_valid = 1'b0; RST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    model_reset();
    seen = 0;
    if (done) seen++;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (done) seen++;
    end
    chk("rst_eval_no_done", 128'(seen), 128'(0));
    check_board("rst_eval");
    v = '{op: OP_UNDO, side: 1'b0, piece: 4'd0, dest: 6'd0, st: 3'd4, cap: 1'b0, cidx: 4'd0};
    run_vec(v, 1'b0, "rst_eval_undo");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/board_state_engine.md
Name: board_state_engine

Overview:
- Parametrised successor to the two-side board updater. Holds per-side piece location tables and alive vectors, and enforces turn order.
- Validates each move before committing it: wrong side, dead piece, or destination on an own piece are rejected.
- Detects captures against live opponent pieces only, and keeps a one-deep undo history.
- Sits between the move generator/search controller and the evaluation logic. Uses a valid/ready move handshake and a single-cycle done/status pulse.

Parameters:
- NUM_PIECES, 16, pieces per side.
- PIDX_W, 4, piece index width; must satisfy 2^PIDX_W >= NUM_PIECES.
- SQ_W, 6, square encoding width.
- CNT_W, 10, move counter width.
- INIT_LOC_W, 96'h20928B30D38F0070460850C4, white reset table. Piece i occupies bits [i*SQ_W +: SQ_W].
- INIT_LOC_B, 96'hC31CB3D35DB7E3FE7EEBDEFC, black reset table, same packing.
- FIRST_SIDE, 1, side to move after reset (1=WHITE, 0=BLACK).

Ports:
- clk  in  1  clock.
- RST  in  1  reset.
- mv_valid  in  1  move request valid.
- mv_ready  out  1  engine can accept a move.
- mv_side  in  1  requesting side (1=WHITE, 0=BLACK).
- mv_piece  in  PIDX_W  moving piece index.
- mv_dest  in  SQ_W  destination square.
- undo  in  1  one-cycle undo request.
- loc_w  out  NUM_PIECES*SQ_W  white location table.
- loc_b  out  NUM_PIECES*SQ_W  black location table.
- alive_w  out  NUM_PIECES  white alive vector.
- alive_b  out  NUM_PIECES  black alive vector.
- turn  out  1  side to move.
- done  out  1  one-cycle completion pulse.
- status  out  3  result code, valid while done=1.
- captured  out  1  accepted move captured a piece, valid with done.
- captured_idx  out  PIDX_W  captured opponent piece index, valid with done.
- move_count  out  CNT_W  committed moves minus undone moves.

Behaviour:
- Interface: reset RST, synchronous, active-high; clock clk.
- Reset values: loc_w=INIT_LOC_W, loc_b=INIT_LOC_B, alive_w/alive_b all 1, turn=FIRST_SIDE, move_count=0, done=0, status=0, captured=0, captured_idx=0, history invalid, FSM=IDLE.
- Status codes: 0 OK, 1 WRONG_TURN, 2 DEAD_PIECE, 3 SELF_BLOCK, 4 UNDO_EMPTY.
- FSM states: IDLE, EVAL, APPLY, UNDO.
- mv_ready = (state==IDLE) && !undo. A move is accepted on the clock edge where mv_valid && mv_ready; mv_side, mv_piece and mv_dest are latched on that edge.
- IDLE -> EVAL on accept. IDLE -> UNDO when undo=1; undo wins over a simultaneous mv_valid, which is not accepted.
- EVAL registers the checks in priority order:
  - mv_side!=turn -> WRONG_TURN.
  - mover not alive -> DEAD_PIECE.
  - mv_dest equals any alive own-side location, the mover included -> SELF_BLOCK.
  - Capture search: opponent pieces with alive=1 and location==mv_dest. If several match, the lowest index is taken.
- APPLY, if OK:
  - Write mover location; clear the captured piece's alive bit.
  - Toggle turn; move_count += 1, saturating at all-ones.
  - Save history: side, piece, old location, capture flag, capture index; history valid.
- APPLY, if rejected: no state or history change.
- APPLY -> IDLE. done=1 in the cycle after APPLY, together with the updated tables. Latency is therefore accept edge + 3 cycles to done.
- UNDO, history valid:
  - Restore mover location; restore captured piece alive bit if one was captured.
  - Toggle turn back; move_count -= 1 unless it is 0.
  - Invalidate history; status OK.
- UNDO, history invalid: status UNDO_EMPTY, no state change.
- UNDO -> IDLE. done pulses in the next cycle. Undo latency is 2 cycles from undo sampled.
- captured and captured_idx are 0 on rejects and on undo.
- mv_valid and undo are ignored outside IDLE.
- Only one undo level is kept: a second consecutive undo returns UNDO_EMPTY.
- RST mid-operation (EVAL/APPLY/UNDO): the pending operation is dropped, no done is produced, and all state takes its reset values.

Test Plan:
- Reset, then white moves piece 15 to square 16 -> done 3 cycles after accept, status 0, loc_w[95:90]=16, turn=0, move_count=1, captured=0.
- Then black moves piece 15 to square 16 -> status 0, alive_w[15]=0, captured=1, captured_idx=15, loc_b[95:90]=16, turn=1, move_count=2.
- Undo -> done 2 cycles later, loc_b[95:90]=48, alive_w[15]=1, turn=0, move_count=1. A second undo -> status 4, no table change.
- From reset, black requests a move -> status 1. White moves piece 15 to square 9 (white piece 14 location) -> status 3, tables unchanged, turn=1.
- Captured piece re-targeted: after white piece 15 is captured, white moves piece 15 -> status 2. A later move onto dead white piece 15's stored square by black is not a capture.
- undo and mv_valid asserted in the same IDLE cycle -> mv_ready=0, only the undo executes. RST asserted during EVAL -> no done, tables equal INIT_LOC_W/INIT_LOC_B, move_count=0.
